// File: rtl/uart_pkg.sv
// Shared register map, bit positions and trigger-level helper for the UART RX controller.
package uart_pkg;

  // Register addresses
  localparam logic [1:0] ADDR_RBR = 2'd0;
  localparam logic [1:0] ADDR_LCR = 2'd1;
  localparam logic [1:0] ADDR_LSR = 2'd2;
  localparam logic [1:0] ADDR_IER = 2'd3;  // IER on read, IER/FCR on write

  // LCR fields
  localparam int LCR_WLS_LO = 0;
  localparam int LCR_WLS_HI = 1;
  localparam int LCR_PEN    = 3;
  localparam int LCR_EPS    = 4;
  localparam int LCR_STICKY = 5;
  localparam logic [7:0] LCR_RESET = 8'h03;

  // LSR fields
  localparam int LSR_DR = 0;
  localparam int LSR_OE = 1;
  localparam int LSR_PE = 2;
  localparam int LSR_FE = 3;
  localparam int LSR_TO = 4;

  // IER/FCR fields
  localparam int IER_RDA     = 0;
  localparam int IER_ERR     = 1;
  localparam int IER_TO      = 2;
  localparam int IER_TRIG_LO = 4;
  localparam int IER_TRIG_HI = 5;
  localparam int FCR_FLUSH   = 7;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_e;

  // FIFO fill level that raises the data-ready interrupt
  function automatic logic [3:0] trig_level(input trig_e t);
    case (t)
      TRIG_1:  trig_level = 4'd1;
      TRIG_4:  trig_level = 4'd4;
      TRIG_8:  trig_level = 4'd8;
      default: trig_level = 4'd14;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous byte FIFO for received characters. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle; flush overrides both.
module rx_fifo #(
  parameter  int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic         baud_clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [7:0]   wdata,
  output logic [7:0]   rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge baud_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Host-side UART receive controller: line-control register, RX FIFO,
// sticky line status, character timeout and a single level interrupt.
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic       baud_clk,
  input  logic       reset_n,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  input  logic [7:0] rx_data_i,
  input  logic       rx_wr_en_i,
  input  logic       rx_done_i,
  input  logic       parity_error_i,
  input  logic       frame_error_i,
  output logic [1:0] wls,
  output logic       pen,
  output logic       eps,
  output logic       sticky_parity,
  output logic       irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

  logic [7:0]    lcr;
  logic [5:0]    ier;
  logic          done_q, rise;
  logic          oe, pe, fe, to;
  logic [TW-1:0] to_cnt;
  logic [7:0]    head, lsr_val;
  logic          full, empty;
  logic [CW-1:0] count, trig_lvl;
  logic          rd_rbr, rd_lsr, wr_lcr, wr_fcr, flush;
  logic          push_req, oe_set, fifo_act, to_set;
  logic          unused_wdata6;

  assign unused_wdata6 = reg_wdata[6];

  assign wls           = lcr[LCR_WLS_HI:LCR_WLS_LO];
  assign pen           = lcr[LCR_PEN];
  assign eps           = lcr[LCR_EPS];
  assign sticky_parity = lcr[LCR_STICKY];

  assign rise     = rx_done_i & ~done_q;
  assign rd_rbr   = reg_rd & (reg_addr == ADDR_RBR);
  assign rd_lsr   = reg_rd & (reg_addr == ADDR_LSR);
  assign wr_lcr   = reg_wr & (reg_addr == ADDR_LCR);
  assign wr_fcr   = reg_wr & (reg_addr == ADDR_IER);
  assign flush    = wr_fcr & reg_wdata[FCR_FLUSH];
  assign push_req = rise & rx_wr_en_i;
  // A pop in the same cycle frees the slot, and a flush discards the byte anyway
  assign oe_set   = push_req & full & ~rd_rbr & ~flush;
  // Any FIFO movement, a flush, or an empty FIFO restarts the idle count
  assign fifo_act = (push_req & ~oe_set) | (rd_rbr & ~empty) | flush | empty;
  assign to_set   = ~fifo_act & (to_cnt == TO_LAST);
  assign trig_lvl = CW'(trig_level(trig_e'(ier[IER_TRIG_HI:IER_TRIG_LO])));

  rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .push     (push_req),
    .pop      (rd_rbr),
    .flush    (flush),
    .wdata    (rx_data_i),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Live LSR view; DR follows FIFO occupancy directly
  always_comb begin
    lsr_val         = '0;
    lsr_val[LSR_DR] = ~empty;
    lsr_val[LSR_OE] = oe;
    lsr_val[LSR_PE] = pe;
    lsr_val[LSR_FE] = fe;
    lsr_val[LSR_TO] = to;
  end

  // Configuration registers and rx_done edge history
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      lcr    <= LCR_RESET;
      ier    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= rx_done_i;
      if (wr_lcr) lcr <= reg_wdata;
      if (wr_fcr) ier <= reg_wdata[5:0];
    end
  end

  // Sticky status flags: cleared by LSR read, a coincident set wins
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      oe <= 1'b0;
      pe <= 1'b0;
      fe <= 1'b0;
      to <= 1'b0;
    end else begin
      oe <= oe_set                     | (oe & ~rd_lsr);
      pe <= (rise & parity_error_i)    | (pe & ~rd_lsr);
      fe <= (rise & frame_error_i)     | (fe & ~rd_lsr);
      to <= to_set                     | (to & ~rd_lsr);
    end
  end

  // Character timeout counter, saturating so TO fires once per expiry
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n)              to_cnt <= '0;
    else if (fifo_act)         to_cnt <= '0;
    else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
  end

  // Registered read data, held between reads
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_rdata <= '0;
    end else if (reg_rd) begin
      case (reg_addr)
        ADDR_RBR: reg_rdata <= empty ? 8'h00 : head;
        ADDR_LCR: reg_rdata <= lcr;
        ADDR_LSR: reg_rdata <= lsr_val;
        default:  reg_rdata <= {2'b00, ier};
      endcase
    end
  end

  // Interrupt level, registered from current FIFO level and sticky flags
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) irq_o <= 1'b0;
    else          irq_o <= (ier[IER_RDA] & (count >= trig_lvl)) |
                           (ier[IER_ERR] & (oe | pe | fe))      |
                           (ier[IER_TO]  & to);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized self-checking bench for uart_rx_ctrl against a queue-based model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
  localparam int TOT   = 640;

  logic       baud_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reg_wr = 1'b0, reg_rd = 1'b0;
  logic [1:0] reg_addr = 2'd0;
  logic [7:0] reg_wdata = 8'h00;
  logic [7:0] reg_rdata;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_wr_en_i = 1'b0, rx_done_i = 1'b0;
  logic       parity_error_i = 1'b0, frame_error_i = 1'b0;
  logic [1:0] wls;
  logic       pen, eps, sticky_parity, irq_o;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_TICKS(TOT)) dut (
    .baud_clk       (baud_clk),
    .reset_n        (reset_n),
    .reg_wr         (reg_wr),
    .reg_rd         (reg_rd),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_rdata      (reg_rdata),
    .rx_data_i      (rx_data_i),
    .rx_wr_en_i     (rx_wr_en_i),
    .rx_done_i      (rx_done_i),
    .parity_error_i (parity_error_i),
    .frame_error_i  (frame_error_i),
    .wls            (wls),
    .pen            (pen),
    .eps            (eps),
    .sticky_parity  (sticky_parity),
    .irq_o          (irq_o)
  );

  always #5 baud_clk = ~baud_clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  byte unsigned q[$];
  bit           m_oe, m_pe, m_fe, m_to;
  logic [7:0]   m_lcr;
  logic [5:0]   m_ier;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic m_reset();
    q.delete();
    m_oe = 0; m_pe = 0; m_fe = 0; m_to = 0;
    m_lcr = 8'h03;
    m_ier = '0;
  endtask

  function automatic logic [7:0] m_lsr();
    return {3'b000, m_to, m_fe, m_pe, m_oe, q.size() != 0};
  endfunction

  function automatic int m_trig();
    case (m_ier[5:4])
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 14;
    endcase
  endfunction

  function automatic logic m_irq();
    return (m_ier[0] && q.size() >= m_trig()) ||
           (m_ier[1] && (m_oe || m_pe || m_fe)) ||
           (m_ier[2] && m_to);
  endfunction

  // One received frame; optionally an RBR read lands on the frame's first cycle
  task automatic frame(input logic [7:0] d, input bit we, input bit pe, input bit fe,
                       input int hold, input bit pop);
    logic [7:0] rd;
    logic [7:0] exp_rd;
    rx_data_i = d; rx_wr_en_i = we; parity_error_i = pe; frame_error_i = fe;
    rx_done_i = 1'b1;
    if (pop) begin reg_rd = 1'b1; reg_addr = 2'd0; end
    tick();
    reg_rd = 1'b0;
    rd = reg_rdata;
    repeat (hold - 1) tick();
    rx_done_i = 1'b0; rx_wr_en_i = 1'b0; parity_error_i = 1'b0; frame_error_i = 1'b0;
    tick();
    exp_rd = 8'h00;
    if (pop && q.size() > 0) exp_rd = q.pop_front();
    if (pop) chk("pop_rd", rd, exp_rd);
    if (we) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_oe = 1;
    end
    if (pe) m_pe = 1;
    if (fe) m_fe = 1;
  endtask

  task automatic rd_reg(input logic [1:0] a, input string tag);
    logic [7:0] exp;
    case (a)
      2'd0: exp = (q.size() > 0) ? q.pop_front() : 8'h00;
      2'd1: exp = m_lcr;
      2'd2: begin exp = m_lsr(); m_oe = 0; m_pe = 0; m_fe = 0; m_to = 0; end
      default: exp = {2'b00, m_ier};
    endcase
    reg_rd = 1'b1; reg_addr = a;
    tick();
    reg_rd = 1'b0;
    chk(tag, reg_rdata, exp);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr = 1'b0;
    if (a == 2'd1) m_lcr = d;
    else if (a == 2'd3) begin
      m_ier = d[5:0];
      if (d[7]) q.delete();
    end
  endtask

  task automatic chk_irq(input string tag);
    tick();
    chk(tag, irq_o, m_irq());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    // 1. reset state
    repeat (3) tick();
    chk("rst_rdata", reg_rdata, 8'h00);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_wls", wls, 2'd3);
    chk("rst_pen", {pen, eps, sticky_parity}, 3'b000);
    reset_n = 1'b1;
    tick();
    rd_reg(2'd1, "rst_lcr");
    rd_reg(2'd3, "rst_ier");
    rd_reg(2'd2, "rst_lsr");

    // 2. long rx_done pulse yields a single push
    frame(8'hA5, 1, 0, 0, 3, 0);
    rd_reg(2'd2, "dr_set");
    rd_reg(2'd0, "rbr_a5");
    rd_reg(2'd2, "dr_clr");
    rd_reg(2'd0, "rbr_empty");

    // 3. trigger level 4 interrupt
    wr_reg(2'd3, 8'h11);
    for (int i = 1; i <= 4; i++) begin
      frame(8'(i), 1, 0, 0, 1, 0);
      chk($sformatf("irq_trig%0d", i), irq_o, m_irq());
    end
    rd_reg(2'd0, "trig_pop");
    chk_irq("irq_trig_drop");
    repeat (3) rd_reg(2'd0, "trig_drain");
    wr_reg(2'd3, 8'h00);

    // 4. overrun and full push+pop
    for (int i = 1; i <= 17; i++) frame(8'(i), 1, 0, 0, 1, 0);
    rd_reg(2'd2, "oe_set");
    for (int i = 1; i <= 16; i++) rd_reg(2'd0, "ovr_data");
    for (int i = 1; i <= 16; i++) frame(8'(i + 32), 1, 0, 0, 1, 0);
    frame(8'hEE, 1, 0, 0, 1, 1);
    rd_reg(2'd2, "full_pushpop_no_oe");
    for (int i = 0; i < 16; i++) rd_reg(2'd0, "pp_data");

    // 5. parity-errored frame is dropped
    wr_reg(2'd3, 8'h02);
    frame(8'h5A, 0, 1, 0, 1, 0);
    chk_irq("irq_pe");
    rd_reg(2'd2, "lsr_pe");
    rd_reg(2'd2, "lsr_pe_clr");
    chk_irq("irq_pe_clr");

    // 6. character timeout, flush keeps TO
    wr_reg(2'd3, 8'h04);
    frame(8'h77, 1, 0, 0, 1, 0);
    repeat (600) tick();
    rd_reg(2'd2, "to_early");
    repeat (100) tick();
    m_to = 1;  // byte has sat untouched for more than TOT ticks
    chk_irq("irq_to");
    wr_reg(2'd3, 8'h84);
    rd_reg(2'd2, "to_after_flush");
    rd_reg(2'd2, "to_clr");
    wr_reg(2'd3, 8'h00);
    frame(8'h31, 1, 0, 0, 1, 0);
    wr_reg(2'd3, 8'h80);
    repeat (TOT + 60) tick();
    rd_reg(2'd2, "flush_cnt_clr");

    // 7. reset in the middle of a frame
    frame(8'h42, 1, 0, 0, 1, 0);
    wr_reg(2'd1, 8'h3B);
    rd_reg(2'd1, "lcr_wr");
    rx_data_i = 8'h99; rx_wr_en_i = 1'b1; rx_done_i = 1'b1;
    @(posedge baud_clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_rdata", reg_rdata, 8'h00);
    chk("midrst_wls", wls, 2'd3);
    rx_done_i = 1'b0; rx_wr_en_i = 1'b0;
    tick();
    reset_n = 1'b1;
    m_reset();
    tick();
    rd_reg(2'd2, "midrst_lsr");
    rd_reg(2'd0, "midrst_rbr");

    // 8. randomized traffic
    for (int n = 0; n < 250; n++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 45) begin
        bit we, pe, fe;
        we = ($urandom_range(0, 9) != 0);
        pe = !we && ($urandom_range(0, 1) == 1);
        fe = ($urandom_range(0, 9) == 0);
        frame(8'($urandom), we, pe, fe, int'($urandom_range(1, 3)), $urandom_range(0, 4) == 0);
      end else if (op < 75) begin
        rd_reg(2'd0, "rnd_rbr");
      end else if (op < 85) begin
        rd_reg(2'd2, "rnd_lsr");
      end else if (op < 93) begin
        logic [7:0] d;
        d = 8'($urandom);
        d[7] = ($urandom_range(0, 7) == 0);
        wr_reg(2'd3, d);
        rd_reg(2'd3, "rnd_ier");
      end else begin
        logic [7:0] d;
        d = 8'($urandom);
        wr_reg(2'd1, d);
        chk("rnd_cfg", {wls, pen, eps, sticky_parity}, {d[1:0], d[3], d[4], d[5]});
        rd_reg(2'd1, "rnd_lcr");
      end
      chk_irq("rnd_irq");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
